quick_mem_bridge: RTL and testbench
===================================

# quick_mem_bridge

Memory and I/O responder sitting directly downstream of the quick CPU core, on the far side of its shared 8-bit address/data bus and `mem_rd`/`mem_wr` strobes. Provides a flop-based program/data RAM, a memory-mapped input and output port, and a host program loader that holds the CPU in reset while filling RAM. Reads are answered combinationally in the same cycle; writes are two-phase (address cycle, then data cycle) and are sequenced by an internal FSM.

## Interface

Parameters:
- `DEPTH`, 32: RAM size in bytes; power of two, 2..128; RAM occupies addresses 0..DEPTH-1.
- `IN_ADDR`, 8'hFE: read-only input port address.
- `OUT_ADDR`, 8'hFF: write-only output port address.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `bus_in`  in  8  CPU bus: address, or write data in the cycle after `mem_wr`
- `mem_rd`  in  1  CPU read strobe, address on `bus_in` this cycle
- `mem_wr`  in  1  CPU write strobe, address on `bus_in` this cycle
- `rdata`  out  8  read data to CPU, combinational
- `in_port`  in  8  external input, returned on reads of `IN_ADDR`
- `out_port`  out  8  registered output port
- `out_strobe`  out  1  one-cycle pulse after each `out_port` write
- `prog_en`  in  1  loader mode; CPU held in reset
- `prog_valid`  in  1  loader byte valid (only honoured when `prog_en`=1)
- `prog_data`  in  8  loader byte
- `cpu_rst_n`  out  1  active-low reset to CPU core

## Operation

- Write FSM, states IDLE and WDATA:
  - IDLE, `mem_wr`=1, `prog_en`=0: latch `bus_in` into `wr_addr`, go WDATA.
  - WDATA: `bus_in` is the write data; commit at clock edge, return to IDLE unconditionally. `mem_wr`/`mem_rd` are ignored in WDATA.
  - Commit target: `wr_addr` < DEPTH writes RAM; `wr_addr`==`OUT_ADDR` loads `out_port` and sets `out_strobe` for the next cycle; any other address: dropped, FSM still returns to IDLE.
- Read path (combinational): `rdata` = RAM[`bus_in`] if `mem_rd`=1 and `bus_in` < DEPTH; `in_port` if `bus_in`==`IN_ADDR`; else 8'h00. `rdata`=0 when `mem_rd`=0, in WDATA, or when `prog_en`=1.
- Reads return pre-commit contents in the same cycle as a commit; new value visible from the next cycle.
- Loader: internal pointer `ptr` (log2 DEPTH bits). While `prog_en`=1, each cycle with `prog_valid`=1 writes `prog_data` to RAM[`ptr`], `ptr`++ with wrap at DEPTH. `ptr` clears to 0 in every cycle with `prog_en`=0.
- `prog_en`=1 forces FSM to IDLE; a pending WDATA write is aborted (no commit).
- `cpu_rst_n`: register, next value = ~`prog_en`.

## Timing

- Reset values: RAM all 0, `out_port`=0, `out_strobe`=0, `cpu_rst_n`=0, FSM IDLE, `ptr`=0, `wr_addr`=0. `rdata` follows read rule (0 unless `mem_rd`).
- Read latency 0 cycles: CPU samples `rdata` at the edge ending the strobe cycle.
- Write: address cycle N (`mem_wr`), data cycle N+1, RAM/`out_port` updated at edge ending N+1; `out_strobe` high during N+2 only.
- `cpu_rst_n` rises one cycle after `prog_en` falls; falls one cycle after `prog_en` rises; first CPU fetch follows release.
- Reset asserted mid-write: write lost, FSM IDLE immediately.
- `mem_rd` and `mem_wr` both high in IDLE: read answered combinationally, write FSM still starts.

## Test plan

- Reset, then `mem_rd`=1, `bus_in`=8'h05 -> `rdata`=8'h00; `cpu_rst_n`=0, `out_port`=0.
- `prog_en`=1, stream 8'h8C, 8'h31, 8'h40 with `prog_valid` -> RAM[0..2] hold these; drop `prog_en` -> `cpu_rst_n`=1 exactly one cycle later; read 0x01 -> 8'h31.
- `mem_wr`, `bus_in`=8'h10, next cycle `bus_in`=8'hA5 -> read 0x10 in following cycle returns 8'hA5; read in data cycle with pre-state 0 returns 0 (ignored strobe).
- Write 8'h7E to 8'hFF -> `out_port`=8'h7E, `out_strobe` high exactly one cycle; write to 8'h40 (DEPTH=32) -> RAM unchanged, no strobe, next write works normally.
- `in_port`=8'h3C, read 8'hFE -> `rdata`=8'h3C; read 8'h20 -> 8'h00.
- Abort: `mem_wr` to 0x03 then `prog_en`=1 in data cycle -> RAM[3] unchanged; loader 33 bytes with DEPTH=32 -> byte 33 overwrites RAM[0].

Source files
------------

// File: rtl/quick_mem_bridge.sv
// Memory/I-O responder behind the quick CPU bus: flop RAM, in/out ports and a host loader.
// Reads are combinational; writes take an address cycle then a data cycle; the loader holds the CPU in reset.
module quick_mem_bridge #(
    parameter int         DEPTH    = 32,
    parameter logic [7:0] IN_ADDR  = 8'hFE,
    parameter logic [7:0] OUT_ADDR = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_in,
    input  logic       mem_rd,
    input  logic       mem_wr,
    output logic [7:0] rdata,
    input  logic [7:0] in_port,
    output logic [7:0] out_port,
    output logic       out_strobe,
    input  logic       prog_en,
    input  logic       prog_valid,
    input  logic [7:0] prog_data,
    output logic       cpu_rst_n
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    typedef enum logic {
        IDLE,
        WDATA
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] mem [DEPTH];
    logic [7:0] wr_addr;
    logic [AW-1:0] ptr;

    logic addr_latch;
    logic wr_commit;
    logic ram_we;
    logic out_we;
    logic rd_in_ram;
    logic wr_in_ram;

    assign rd_in_ram = ({1'b0, bus_in} < DEPTH_W);
    assign wr_in_ram = ({1'b0, wr_addr} < DEPTH_W);

    // prog_en overrides the write sequencer: a pending data cycle is dropped.
    always_comb begin
        state_nxt  = state;
        addr_latch = 1'b0;
        wr_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_wr && !prog_en) begin
                    state_nxt  = WDATA;
                    addr_latch = 1'b1;
                end
            end
            WDATA: begin
                state_nxt = IDLE;
                wr_commit = !prog_en;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_we = wr_commit && wr_in_ram;
    assign out_we = wr_commit && (wr_addr == OUT_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (addr_latch) begin
                wr_addr <= bus_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (prog_en && prog_valid) begin
            mem[ptr] <= prog_data;
        end else if (ram_we) begin
            mem[wr_addr[AW-1:0]] <= bus_in;
        end
    end

    // DEPTH is a power of two, so the natural overflow of ptr is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (!prog_en) begin
            ptr <= '0;
        end else if (prog_valid) begin
            ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_port   <= '0;
            out_strobe <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            out_strobe <= out_we;
            cpu_rst_n  <= ~prog_en;
            if (out_we) begin
                out_port <= bus_in;
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (mem_rd && !prog_en && (state == IDLE)) begin
            if (rd_in_ram) begin
                rdata = mem[bus_in[AW-1:0]];
            end else if (bus_in == IN_ADDR) begin
                rdata = in_port;
            end
        end
    end

endmodule

// File: tb/tb_quick_mem_bridge.sv
// Directed bench for quick_mem_bridge: a transaction-level model checked every cycle plus literal pins.
module tb_quick_mem_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       mem_rd, mem_wr;
    logic [7:0] rdata;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic       out_strobe;
    logic       prog_en, prog_valid;
    logic [7:0] prog_data;
    logic       cpu_rst_n;

    int tests = 0;
    int fails = 0;

    quick_mem_bridge #(.DEPTH(32), .IN_ADDR(8'hFE), .OUT_ADDR(8'hFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_in     (bus_in),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .rdata      (rdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .out_strobe (out_strobe),
        .prog_en    (prog_en),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    // Model: byte array plus "a write address is waiting for its data byte".
    logic [7:0] m_ram [32];
    bit         m_pending;
    logic [7:0] m_addr;
    logic [7:0] m_out;
    bit         m_strobe;
    bit         m_cpu;
    int         m_ptr;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h00;
        m_pending = 0;
        m_addr    = 8'h00;
        m_out     = 8'h00;
        m_strobe  = 0;
        m_cpu     = 0;
        m_ptr     = 0;
    endtask

    function automatic logic [7:0] model_rdata();
        if (!mem_rd || m_pending || prog_en) return 8'h00;
        if (bus_in < 8'd32) return m_ram[bus_in];
        if (bus_in == 8'hFE) return in_port;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            m_strobe = 0;
            if (prog_en) begin
                m_pending = 0;
                if (prog_valid) begin
                    m_ram[m_ptr] = prog_data;
                    m_ptr = (m_ptr + 1) % 32;
                end
            end else begin
                m_ptr = 0;
                if (m_pending) begin
                    if (m_addr < 8'd32) m_ram[m_addr] = bus_in;
                    else if (m_addr == 8'hFF) begin
                        m_out    = bus_in;
                        m_strobe = 1;
                    end
                    m_pending = 0;
                end else if (mem_wr) begin
                    m_pending = 1;
                    m_addr    = bus_in;
                end
            end
            m_cpu = !prog_en;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (rdata !== model_rdata()) begin
                fails++;
                $display("FAIL model_rdata t=%0t bus=%h got=%h exp=%h", $time, bus_in, rdata, model_rdata());
            end
            tests++;
            if (out_port !== m_out || out_strobe !== m_strobe) begin
                fails++;
                $display("FAIL model_out t=%0t got=%h/%b exp=%h/%b", $time, out_port, out_strobe, m_out, m_strobe);
            end
            tests++;
            if (cpu_rst_n !== m_cpu) begin
                fails++;
                $display("FAIL model_cpu_rst_n t=%0t got=%b exp=%b", $time, cpu_rst_n, m_cpu);
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drive one bus cycle just after the edge, then let combinational outputs settle.
    task automatic step(input logic rd, input logic wr, input logic [7:0] b,
                        input logic pe, input logic pv, input logic [7:0] pd);
        @(posedge clk);
        #1;
        mem_rd = rd; mem_wr = wr; bus_in = b;
        prog_en = pe; prog_valid = pv; prog_data = pd;
        #1;
    endtask

    task automatic rd(input logic [7:0] a);
        step(1, 0, a, 0, 0, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(0, 1, a, 0, 0, 8'h00);
        step(0, 0, d, 0, 0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        mem_rd = 1'b1; mem_wr = 1'b0; bus_in = 8'h05; in_port = 8'h00;
        prog_en = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        #12;
        lit("reset_rdata", rdata, 8'h00);
        lit("reset_cpu_rst_n", {7'b0, cpu_rst_n}, 8'h00);
        lit("reset_out_port", out_port, 8'h00);
        lit("reset_out_strobe", {7'b0, out_strobe}, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;

        // Loader, with an ignored read while loading
        step(1, 0, 8'h00, 1, 1, 8'h8C);
        lit("rd_during_load", rdata, 8'h00);
        step(0, 0, 8'h00, 1, 1, 8'h31);
        step(0, 0, 8'h00, 1, 1, 8'h40);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        lit("cpu_rst_still_low", {7'b0, cpu_rst_n}, 8'h00);
        rd(8'h01);
        lit("cpu_rst_released", {7'b0, cpu_rst_n}, 8'h01);
        lit("rd_ram1", rdata, 8'h31);
        rd(8'h02);
        lit("rd_ram2", rdata, 8'h40);

        // Two-phase write with a read strobe in the data cycle
        step(0, 1, 8'h10, 0, 0, 8'h00);
        step(1, 0, 8'hA5, 0, 0, 8'h00);
        lit("rd_in_data_cycle", rdata, 8'h00);
        rd(8'h10);
        lit("rd_after_write", rdata, 8'hA5);

        // Output port and dropped write
        wr(8'hFF, 8'h7E);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        lit("out_port", out_port, 8'h7E);
        lit("out_strobe_hi", {7'b0, out_strobe}, 8'h01);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        lit("out_strobe_lo", {7'b0, out_strobe}, 8'h00);
        wr(8'h40, 8'h99);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        lit("no_strobe_dropped", {7'b0, out_strobe}, 8'h00);
        rd(8'h00);
        lit("dropped_no_alias", rdata, 8'h8C);
        wr(8'h11, 8'h5A);
        rd(8'h11);
        lit("write_after_drop", rdata, 8'h5A);

        // Input port and unmapped read
        in_port = 8'h3C;
        rd(8'hFE);
        lit("in_port_rd", rdata, 8'h3C);
        rd(8'h20);
        lit("unmapped_rd", rdata, 8'h00);
        rd(8'hFF);
        lit("out_addr_rd", rdata, 8'h00);

        // Abort by prog_en in the data cycle
        step(0, 1, 8'h03, 0, 0, 8'h00);
        step(0, 0, 8'h77, 1, 0, 8'h00);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        rd(8'h03);
        lit("abort_no_commit", rdata, 8'h00);

        // Loader wrap: byte 33 lands on RAM[0]
        for (int i = 0; i < 32; i++) step(0, 0, 8'h00, 1, 1, 8'(8'hC0 + i));
        step(0, 0, 8'h00, 1, 1, 8'hEE);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        rd(8'h00);
        lit("wrap_ram0", rdata, 8'hEE);
        rd(8'h1F);
        lit("wrap_ram31", rdata, 8'hDF);

        // Simultaneous read and write strobes in IDLE
        step(1, 1, 8'h02, 0, 0, 8'h00);
        lit("rd_wr_same_cycle", rdata, 8'hC2);
        step(0, 0, 8'h66, 0, 0, 8'h00);
        rd(8'h02);
        lit("rd_wr_commit", rdata, 8'h66);

        // Reset during the data cycle loses the write and clears RAM
        step(0, 1, 8'h04, 0, 0, 8'h00);
        step(0, 0, 8'h55, 0, 0, 8'h00);
        rst_n = 1'b0;
        model_reset();
        #1;
        lit("midwrite_reset_cpu", {7'b0, cpu_rst_n}, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        rd(8'h04);
        lit("midwrite_lost", rdata, 8'h00);
        rd(8'h02);
        lit("reset_clears_ram", rdata, 8'h00);
        wr(8'h04, 8'h12);
        rd(8'h04);
        lit("write_after_reset", rdata, 8'h12);
        step(0, 0, 8'h00, 0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
